// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: shares one external LFSR between two requesters.
// A round-robin arbiter picks a requester in IDLE, then the FSM loads that
// requester's seed into the LFSR, applies cnt shifts and presents the LFSR
// word on a valid/ready response channel tagged with the requester id.
//
// Handshakes:
//   request side : ackN is a one-cycle, combinational accept strobe. seedN/cntN
//                  are captured on the clock edge where ackN=1. There is no
//                  back-pressure; a requester keeps reqN high until it sees ackN.
//   response side: rsp_valid/rsp_data/rsp_id stay stable while rsp_valid=1 and
//                  rsp_ready=0. The word is consumed on the edge where both are 1.
module lfsr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] seed0,
  input  logic [CNT_W-1:0] cnt0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] cnt1,
  output logic             ack1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_init,
  output logic             lfsr_shift,
  input  logic [WIDTH-1:0] lfsr_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             id_q, id_d;
  logic             grant;

  // State and transaction registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      seed_q       <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      seed_q       <= seed_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      id_q         <= id_d;
    end
  end

  // Next-state, arbitration and all LFSR/response outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    seed_d       = seed_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    id_d         = id_q;
    ack0         = 1'b0;
    ack1         = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    rsp_id       = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_init    = '0;
    lfsr_shift   = 1'b0;
    // Tie goes to the requester not served last; otherwise the lone requester.
    grant        = (req0 && req1) ? ~last_grant_q : req1;

    unique case (state_q)
      IDLE: begin
        // ack is masked while rst is high so every output reads 0 during reset.
        if ((req0 || req1) && !rst) begin
          ack0         = ~grant;
          ack1         = grant;
          seed_d       = grant ? seed1 : seed0;
          cnt_d        = grant ? cnt1 : cnt0;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
        lfsr_init = seed_q;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          rem_d   = cnt_q;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_shift = 1'b1;
        rem_d      = rem_q - CNT_W'(1);
        // Leaving on rem==1 means exactly cnt_q shift cycles were spent here.
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // No shift is applied here, so lfsr_result is stable for the whole hold.
        rsp_valid = 1'b1;
        rsp_data  = lfsr_result;
        rsp_id    = id_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // The remaining-shift counter must never be zero while shifting, otherwise it would wrap.
  rem_nonzero_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == SHIFT) |-> (rem_q != '0));

endmodule
